// File: rtl/switch_rr_scheduler_if.sv
// Request/grant bundle between the per-port input stages and the output scheduler.
interface switch_rr_scheduler_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
    logic [NUM_PORTS-1:0]           port_reqs;
    logic [NUM_PORTS*NUM_PORTS-1:0] port_dst;
    logic [NUM_PORTS-1:0]           grant_bus;
    logic [NUM_PORTS*SEL_W-1:0]     mux_sel_bus;
    logic [NUM_PORTS-1:0]           active;
    logic [NUM_PORTS-1:0]           err_illegal;

    modport master (
        output port_reqs, port_dst,
        input  grant_bus, mux_sel_bus, active, err_illegal
    );

    modport slave (
        input  port_reqs, port_dst,
        output grant_bus, mux_sel_bus, active, err_illegal
    );
endinterface

// File: rtl/switch_rr_scheduler.sv
// Per-output round-robin allocator: grants one input per output for HOLD_CYCLES,
// and drops head packets whose destination is not exactly one-hot.
module switch_rr_scheduler #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    switch_rr_scheduler_if.slave sw
);
    localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_XFER} state_e;

    state_e               state_q [NUM_PORTS];
    state_e               state_d [NUM_PORTS];
    logic [SEL_W-1:0]     ptr_q   [NUM_PORTS];
    logic [SEL_W-1:0]     ptr_d   [NUM_PORTS];
    logic [SEL_W-1:0]     sel_q   [NUM_PORTS];
    logic [SEL_W-1:0]     sel_d   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic [NUM_PORTS-1:0] active_q, active_d;
    logic [NUM_PORTS-1:0] busy_in;
    logic [NUM_PORTS-1:0] legal;
    logic                 found;
    int unsigned          idx;

    // An input is busy while it feeds an output or while its drop is in flight.
    always_comb begin
        busy_in = err_q;
        legal   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            legal[i] = $onehot(sw.port_dst[i*NUM_PORTS +: NUM_PORTS]);
        end
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == S_XFER) begin
                busy_in[sel_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_d  = '0;
        err_d    = '0;
        active_d = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            ptr_d[o]   = ptr_q[o];
            sel_d[o]   = sel_q[o];
            cnt_d[o]   = cnt_q[o];
        end

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (sw.port_reqs[i] && !legal[i] && !busy_in[i]) begin
                grant_d[i] = 1'b1;
                err_d[i]   = 1'b1;
            end
        end

        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            case (state_q[o])
                S_IDLE: begin
                    found = 1'b0;
                    // Cyclic scan starting at this output's pointer.
                    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                        idx = (32'(ptr_q[o]) + k) % NUM_PORTS;
                        if (!found && sw.port_reqs[idx] && legal[idx] && !busy_in[idx]
                            && sw.port_dst[idx*NUM_PORTS + o]) begin
                            found        = 1'b1;
                            sel_d[o]     = SEL_W'(idx);
                            grant_d[idx] = 1'b1;
                        end
                    end
                    if (found) begin
                        state_d[o]  = S_XFER;
                        active_d[o] = 1'b1;
                        cnt_d[o]    = CNT_W'(HOLD_CYCLES - 1);
                    end
                end
                S_XFER: begin
                    if (cnt_q[o] != '0) begin
                        cnt_d[o]    = cnt_q[o] - CNT_W'(1);
                        active_d[o] = 1'b1;
                    end else begin
                        state_d[o] = S_IDLE;
                        ptr_d[o]   = SEL_W'((32'(sel_q[o]) + 1) % NUM_PORTS);
                    end
                end
                default: state_d[o] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= S_IDLE;
                ptr_q[o]   <= '0;
                sel_q[o]   <= '0;
                cnt_q[o]   <= '0;
            end
            grant_q  <= '0;
            err_q    <= '0;
            active_q <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
                sel_q[o]   <= sel_d[o];
                cnt_q[o]   <= cnt_d[o];
            end
            grant_q  <= grant_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign sw.grant_bus   = grant_q;
    assign sw.err_illegal = err_q;
    assign sw.active      = active_q;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_sel
        assign sw.mux_sel_bus[o*SEL_W +: SEL_W] = sel_q[o];
    end
endmodule

// File: tb/tb_switch_rr_scheduler.sv
// Directed bench for switch_rr_scheduler with HOLD_CYCLES of 1, 2 and 4 side by side.
module tb_switch_rr_scheduler;
    typedef struct {
        logic [3:0]  reqs;
        logic [15:0] dst;
        logic [3:0]  grant;
        logic [3:0]  act;
        logic [3:0]  err;
        logic [7:0]  sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reqs;
    logic [15:0] dst;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [8];
    logic [3:0]  rr_g [4];
    logic [1:0]  rr_s [4];

    always #5 clk = ~clk;

    switch_rr_scheduler_if #(.NUM_PORTS(4)) if1 ();
    switch_rr_scheduler_if #(.NUM_PORTS(4)) if2 ();
    switch_rr_scheduler_if #(.NUM_PORTS(4)) if4 ();

    assign if1.port_reqs = reqs;
    assign if1.port_dst  = dst;
    assign if2.port_reqs = reqs;
    assign if2.port_dst  = dst;
    assign if4.port_reqs = reqs;
    assign if4.port_dst  = dst;

    switch_rr_scheduler #(.NUM_PORTS(4), .HOLD_CYCLES(1)) d1 (.clk(clk), .rst(rst), .sw(if1));
    switch_rr_scheduler #(.NUM_PORTS(4), .HOLD_CYCLES(2)) d2 (.clk(clk), .rst(rst), .sw(if2));
    switch_rr_scheduler #(.NUM_PORTS(4), .HOLD_CYCLES(4)) d4 (.clk(clk), .rst(rst), .sw(if4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        reqs = '0;
        dst  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // {reqs, dst, grant, active, err, mux_sel_bus} for HOLD_CYCLES=1 from reset
        vecs[0] = '{4'b0001, 16'h0004, 4'b0001, 4'b0100, 4'b0000, 8'h00};
        vecs[1] = '{4'b1111, 16'h2148, 4'b1111, 4'b1111, 4'b0000, 8'h1E};
        vecs[2] = '{4'b0100, 16'h0000, 4'b0100, 4'b0000, 4'b0100, 8'h00};
        vecs[3] = '{4'b0100, 16'h0600, 4'b0100, 4'b0000, 4'b0100, 8'h00};
        vecs[4] = '{4'b0110, 16'h0880, 4'b0010, 4'b1000, 4'b0000, 8'h40};
        vecs[5] = '{4'b1001, 16'hC001, 4'b1001, 4'b0001, 4'b1000, 8'h00};
        vecs[6] = '{4'b0000, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000, 8'h00};
        vecs[7] = '{4'b1001, 16'h1001, 4'b0001, 4'b0001, 4'b0000, 8'h00};
        rr_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        rr_s = '{2'd0, 2'd1, 2'd3, 2'd0};

        // Reset holds everything low even with live requests.
        rst  = 1'b1;
        reqs = 4'b1111;
        dst  = 16'h2148;
        repeat (3) @(negedge clk);
        chk("reset grant", 32'(if1.grant_bus | if2.grant_bus | if4.grant_bus), 32'h0);
        chk("reset active", 32'(if1.active | if2.active | if4.active), 32'h0);
        chk("reset err", 32'(if1.err_illegal | if2.err_illegal | if4.err_illegal), 32'h0);
        chk("reset sel", 32'(if1.mux_sel_bus | if2.mux_sel_bus | if4.mux_sel_bus), 32'h0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            reqs = vecs[v].reqs;
            dst  = vecs[v].dst;
            @(negedge clk);
            chk($sformatf("vec%0d grant", v), 32'(if1.grant_bus), 32'(vecs[v].grant));
            chk($sformatf("vec%0d active", v), 32'(if1.active), 32'(vecs[v].act));
            chk($sformatf("vec%0d err", v), 32'(if1.err_illegal), 32'(vecs[v].err));
            chk($sformatf("vec%0d sel", v), 32'(if1.mux_sel_bus), 32'(vecs[v].sel));
            reqs = '0;
            dst  = '0;
            @(negedge clk);
            chk($sformatf("vec%0d active after", v), 32'(if1.active), 32'h0);
            chk($sformatf("vec%0d grant after", v), 32'(if1.grant_bus | if1.err_illegal), 32'h0);
        end

        // Persistent illegal request is dropped every other cycle.
        do_reset();
        reqs = 4'b0100;
        dst  = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("drop grant k%0d", k), 32'(if1.grant_bus), (k % 2 == 1) ? 32'h4 : 32'h0);
            chk($sformatf("drop err k%0d", k), 32'(if1.err_illegal), (k % 2 == 1) ? 32'h4 : 32'h0);
            chk($sformatf("drop active k%0d", k), 32'(if1.active), 32'h0);
        end

        // Round robin on output 1 with HOLD_CYCLES=2.
        do_reset();
        reqs = 4'b1011;
        dst  = 16'h2022;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k % 3 == 1) begin
                chk($sformatf("rr grant k%0d", k), 32'(if2.grant_bus), 32'(rr_g[(k-1)/3]));
                chk($sformatf("rr sel k%0d", k), 32'(if2.mux_sel_bus[3:2]), 32'(rr_s[(k-1)/3]));
            end else begin
                chk($sformatf("rr grant k%0d", k), 32'(if2.grant_bus), 32'h0);
            end
            chk($sformatf("rr active k%0d", k), 32'(if2.active), (k % 3 != 0) ? 32'h2 : 32'h0);
        end

        // Reset mid-transfer with HOLD_CYCLES=4; pointer must return to 0.
        do_reset();
        reqs = 4'b0010;
        dst  = 16'h0010;
        @(negedge clk);
        chk("mid first grant", 32'(if4.grant_bus), 32'h2);
        repeat (3) @(negedge clk);
        chk("mid last active", 32'(if4.active), 32'h1);
        reqs = 4'b0110;
        dst  = 16'h0110;
        @(negedge clk);
        chk("mid bubble", 32'(if4.active | if4.grant_bus), 32'h0);
        @(negedge clk);
        chk("mid ptr grant", 32'(if4.grant_bus), 32'h4);
        chk("mid ptr sel", 32'(if4.mux_sel_bus[1:0]), 32'h2);
        @(negedge clk);
        chk("mid second active", 32'(if4.active), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst active", 32'(if4.active), 32'h0);
        chk("mid rst grant", 32'(if4.grant_bus | if4.err_illegal), 32'h0);
        chk("mid rst sel", 32'(if4.mux_sel_bus), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid regrant", 32'(if4.grant_bus), 32'h2);
        chk("mid regrant active", 32'(if4.active), 32'h1);
        chk("mid regrant sel", 32'(if4.mux_sel_bus[1:0]), 32'h1);

        // Busy input changes destination mid-transfer; output 0 must wait.
        do_reset();
        reqs = 4'b0010;
        dst  = 16'h0080;
        @(negedge clk);
        chk("busy grant", 32'(if4.grant_bus), 32'h2);
        chk("busy active", 32'(if4.active), 32'h8);
        chk("busy sel", 32'(if4.mux_sel_bus[7:6]), 32'h1);
        dst = 16'h0010;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("busy hold active k%0d", k), 32'(if4.active), (k <= 4) ? 32'h8 : 32'h0);
            chk($sformatf("busy hold grant k%0d", k), 32'(if4.grant_bus | if4.err_illegal), 32'h0);
        end
        @(negedge clk);
        chk("busy regrant", 32'(if4.grant_bus), 32'h2);
        chk("busy regrant active", 32'(if4.active), 32'h1);
        chk("busy regrant sel", 32'(if4.mux_sel_bus[1:0]), 32'h1);

        reqs = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
